// File: rtl/cgra_config_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cgra_config_loader                                           |
// | Description : Upstream configuration/run sequencer for the 2x2 CGRA array. |
// |               Collects 32-bit config words into a shadow buffer, commits   |
// |               the 256-bit instruction bus atomically, releases the tile    |
// |               resets for a programmed number of cycles, then captures the  |
// |               array result and offers it on a valid/ready port.            |
// | Build macro : CFG_PARITY_EN - adds cfg_parity input (even parity over      |
// |               cfg_data); a bad word drops the whole frame and pulses       |
// |               cfg_err for one cycle. Undefined: no check, cfg_err = 0.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk          : clock, all state on the rising edge
//   rst          : asynchronous active-low reset
//   cfg_data     : config word            cfg_valid/cfg_ready : word handshake
//   cfg_parity   : even parity bit (CFG_PARITY_EN builds only)
//   run_cycles   : tile run length, sampled at commit (0 treated as 1)
//   instruction  : per-tile instruction bus, tile t on [64t+63:64t]
//   tile_rst     : per-tile reset, 1 = held in reset
//   final_output : array result, captured on the last run cycle
//   result_data/result_valid/result_ready : result handshake
//   busy         : sequencer is not accepting config words
//   cfg_err      : one-cycle pulse on a parity-failed word
module cgra_config_loader #(
  parameter int NUM_TILES = 4,
  parameter int INSTR_W   = 64,
  parameter int DATA_W    = 32,
  parameter int RUN_CNT_W = 16,
  parameter int RESULT_W  = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              cfg_data,
`ifdef CFG_PARITY_EN
  input  logic                           cfg_parity,
`endif
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [RUN_CNT_W-1:0]           run_cycles,
  output logic [NUM_TILES*INSTR_W-1:0]   instruction,
  output logic [NUM_TILES-1:0]           tile_rst,
  input  logic [RESULT_W-1:0]            final_output,
  output logic [RESULT_W-1:0]            result_data,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           busy,
  output logic                           cfg_err
);

  localparam int BUS_W = NUM_TILES * INSTR_W;
  localparam int WORDS = BUS_W / DATA_W;
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t                 state_q,        state_d;
  logic [CNT_W-1:0]       word_cnt_q,     word_cnt_d;
  logic [BUS_W-1:0]       shadow_q,       shadow_d;
  logic [BUS_W-1:0]       instruction_q,  instruction_d;
  logic [NUM_TILES-1:0]   tile_rst_q,     tile_rst_d;
  logic [RUN_CNT_W-1:0]   run_cnt_q,      run_cnt_d;
  logic [RESULT_W-1:0]    result_data_q,  result_data_d;
  logic                   result_valid_q, result_valid_d;
  logic                   cfg_err_q,      cfg_err_d;

  logic                   accept;
  logic                   parity_bad;
  logic [BUS_W-1:0]       shadow_merged;

`ifdef CFG_PARITY_EN
  assign parity_bad = ^{cfg_data, cfg_parity};
`else
  assign parity_bad = 1'b0;
`endif

  // Gating with rst keeps cfg_ready low for the whole reset window,
  // not just after the flops have settled.
  assign cfg_ready = (state_q == ST_LOAD) && rst;
  assign accept    = cfg_valid && cfg_ready;

  // Shadow with the incoming word already inserted; the commit copies this
  // so the final word reaches the tiles on the same edge it is accepted.
  always_comb begin
    shadow_merged = shadow_q;
    shadow_merged[int'(word_cnt_q) * DATA_W +: DATA_W] = cfg_data;
  end

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    shadow_d       = shadow_q;
    instruction_d  = instruction_q;
    tile_rst_d     = tile_rst_q;
    run_cnt_d      = run_cnt_q;
    result_data_d  = result_data_q;
    result_valid_d = result_valid_q;
    cfg_err_d      = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (parity_bad) begin
            // Drop the whole frame; the next accepted word restarts at tile 0.
            word_cnt_d = '0;
            cfg_err_d  = 1'b1;
          end else if (word_cnt_q == LAST_WORD) begin
            shadow_d      = shadow_merged;
            instruction_d = shadow_merged;
            tile_rst_d    = '0;
            run_cnt_d     = (run_cycles == '0) ? RUN_CNT_W'(1) : run_cycles;
            word_cnt_d    = '0;
            state_d       = ST_RUN;
          end else begin
            shadow_d   = shadow_merged;
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
        // run_cnt==1 marks the last cycle the tiles are out of reset, so
        // final_output is sampled while the array is still live.
        if (run_cnt_q == RUN_CNT_W'(1)) begin
          result_data_d  = final_output;
          result_valid_d = 1'b1;
          tile_rst_d     = '1;
          state_d        = ST_OUT;
        end
      end

      ST_OUT: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = ST_LOAD;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_LOAD;
      word_cnt_q     <= '0;
      shadow_q       <= '0;
      instruction_q  <= '0;
      tile_rst_q     <= '1;
      run_cnt_q      <= '0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      shadow_q       <= shadow_d;
      instruction_q  <= instruction_d;
      tile_rst_q     <= tile_rst_d;
      run_cnt_q      <= run_cnt_d;
      result_data_q  <= result_data_d;
      result_valid_q <= result_valid_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  assign instruction  = instruction_q;
  assign tile_rst     = tile_rst_q;
  assign result_data  = result_data_q;
  assign result_valid = result_valid_q;
  assign busy         = (state_q != ST_LOAD);
  assign cfg_err      = cfg_err_q;

endmodule
`default_nettype wire
